// File: rtl/register_mode_pkg.sv
// Shared types and helpers for the register-mode datapath stage.
package register_mode_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_DELAY  = 2'd2,
        MODE_FIFO   = 2'd3
    } mode_e;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_mode_fifo_mem.sv
// DEPTH x WIDTH circular buffer with read/write pointers and occupancy.
// Flush empties the buffer by snapping rd_ptr onto wr_ptr.
module register_mode_fifo_mem
    import register_mode_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              wr_data,
    output logic [WIDTH-1:0]              rd_data,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/register_mode_fifo.sv
// Configurable per-PE datapath stage: CONST, BYPASS, DELAY or FIFO mode
// with ready/valid handshakes on both sides.
// Build option: REGISTER_MODE_FIFO_FALLTHROUGH_EN lets an empty FIFO pass
// input straight to the output in the same cycle.
module register_mode_fifo
    import register_mode_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
)
(
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              const_,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          clk_en,
    input  logic                          config_we,
    input  logic [WIDTH-1:0]              config_data,
    output logic [WIDTH-1:0]              reg_value,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    mode_e            mode_cur;
    mode_e            mode_q;
    logic             mode_chg;
    logic [WIDTH-1:0] hold;
    logic             delay_valid;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd;
    logic [CW-1:0]    fifo_count;
    logic             fall_through;

    assign mode_cur = mode_e'(mode);
    assign mode_chg = (mode_cur != mode_q);

`ifdef REGISTER_MODE_FIFO_FALLTHROUGH_EN
    assign fall_through = (mode_cur == MODE_FIFO) & fifo_empty & clk_en &
                          in_valid & out_ready & ~config_we;
`else
    assign fall_through = 1'b0;
`endif

    // Output mux per mode; a config write always blocks the upstream side.
    always_comb begin
        out_data  = in_data;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (mode_cur)
            MODE_CONST: begin
                out_data  = const_;
                out_valid = 1'b1;
                in_ready  = 1'b1;
            end
            MODE_BYPASS: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
            end
            MODE_DELAY: begin
                out_data  = hold;
                out_valid = delay_valid;
                in_ready  = clk_en & (~delay_valid | out_ready);
            end
            MODE_FIFO: begin
                if (fall_through) begin
                    out_data  = in_data;
                    out_valid = 1'b1;
                    in_ready  = 1'b1;
                end else begin
                    out_data  = fifo_rd;
                    out_valid = clk_en & ~fifo_empty;
                    in_ready  = clk_en & ~fifo_full;
                end
            end
            default: ;
        endcase
        if (config_we) in_ready = 1'b0;
    end

    // Fall-through beats never touch storage; flush outranks push/pop inside the buffer.
    assign fifo_push  = (mode_cur == MODE_FIFO) & in_valid & in_ready & ~fall_through;
    assign fifo_pop   = (mode_cur == MODE_FIFO) & out_valid & out_ready & ~fall_through;
    assign fifo_flush = config_we | mode_chg;

    register_mode_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .reset   (RESET),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (in_data),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Hold register, delay-valid and mode tracking: reset > config > mode change > datapath.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold        <= INIT;
            delay_valid <= 1'b0;
            mode_q      <= mode_cur;
        end else begin
            mode_q <= mode_cur;
            if (config_we) begin
                hold        <= config_data;
                delay_valid <= 1'b1;
            end else if (mode_chg) begin
                delay_valid <= 1'b0;
            end else if (mode_cur == MODE_DELAY && clk_en) begin
                if (in_valid && in_ready) begin
                    hold        <= in_data;
                    delay_valid <= 1'b1;
                end else if (out_ready) begin
                    delay_valid <= 1'b0;
                end
            end
        end
    end

    assign reg_value = hold;
    assign count     = (mode_cur == MODE_FIFO) ? fifo_count : '0;

endmodule

// File: tb/tb_register_mode_fifo.sv
// Randomized and directed bench for register_mode_fifo against a queue-based model.
module tb_register_mode_fifo;

    localparam int          W    = 16;
    localparam int          D    = 4;
    localparam logic [15:0] INIT = 16'h00C3;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [1:0]    mode;
    logic [W-1:0]  const_;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clk_en;
    logic          config_we;
    logic [W-1:0]  config_data;
    logic [W-1:0]  reg_value;
    logic [2:0]    count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [15:0] m_hold;
    logic        m_dv;
    logic [15:0] m_q[$];
    logic [1:0]  m_mode_q;
    logic        m_known = 1'b0;

    register_mode_fifo #(
        .WIDTH (W),
        .DEPTH (D),
        .INIT  (INIT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .mode        (mode),
        .const_      (const_),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clk_en      (clk_en),
        .config_we   (config_we),
        .config_data (config_data),
        .reg_value   (reg_value),
        .count       (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [1:0] md, input logic iv, input logic [15:0] id,
                          input logic orr, input logic ce);
        mode      = md;
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        clk_en    = ce;
        config_we = 1'b0;
    endtask

    // Compare against the model mid-cycle, clock once, advance the model.
    task automatic step();
        logic [15:0] e_od;
        logic        e_ov, e_ir, cmp_od, ft;
        #2;
        ft = 1'b0;
`ifdef REGISTER_MODE_FIFO_FALLTHROUGH_EN
        ft = (mode == 2'd3) && (m_q.size() == 0) && clk_en && in_valid && out_ready && !config_we;
`endif
        e_od = '0; e_ov = 1'b0; e_ir = 1'b0; cmp_od = 1'b1;
        case (mode)
            2'd0: begin e_od = const_;  e_ov = 1'b1;     e_ir = 1'b1; end
            2'd1: begin e_od = in_data; e_ov = in_valid; e_ir = out_ready; end
            2'd2: begin e_od = m_hold;  e_ov = m_dv;     e_ir = clk_en && (!m_dv || out_ready); end
            default: begin
                if (ft) begin
                    e_od = in_data; e_ov = 1'b1; e_ir = 1'b1;
                end else begin
                    e_ov   = clk_en && (m_q.size() > 0);
                    e_ir   = clk_en && (m_q.size() < D);
                    e_od   = (m_q.size() > 0) ? m_q[0] : 16'h0;
                    cmp_od = e_ov;
                end
            end
        endcase
        if (config_we) e_ir = 1'b0;
        if (m_known) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
            check("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
            if (cmp_od) check("out_data", {16'b0, out_data}, {16'b0, e_od});
            check("reg_value", {16'b0, reg_value}, {16'b0, m_hold});
            check("count", {29'b0, count}, (mode == 2'd3) ? m_q.size() : 0);
        end
        @(posedge CLK);
        if (RESET) begin
            m_hold = INIT; m_dv = 1'b0; m_q.delete(); m_mode_q = mode; m_known = 1'b1;
        end else if (config_we) begin
            m_hold = config_data; m_dv = 1'b1; m_q.delete(); m_mode_q = mode;
        end else if (mode != m_mode_q) begin
            m_q.delete(); m_dv = 1'b0; m_mode_q = mode;
        end else if (clk_en) begin
            if (mode == 2'd2) begin
                if (in_valid && e_ir) begin m_hold = in_data; m_dv = 1'b1; end
                else if (out_ready) m_dv = 1'b0;
            end else if (mode == 2'd3 && !ft) begin
                if (e_ov && out_ready) void'(m_q.pop_front());
                if (in_valid && e_ir) m_q.push_back(in_data);
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; const_ = 16'h00A5; config_data = '0;
        set_in(2'd0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset then CONST
        step();
        RESET = 1'b0;
        #1;
        check("t1_ov", {31'b0, out_valid}, 1);
        check("t1_od", {16'b0, out_data}, 32'h00A5);
        check("t1_reg", {16'b0, reg_value}, {16'b0, INIT});
        check("t1_cnt", {29'b0, count}, 0);
        step();

        // DELAY stream
        set_in(2'd2, 1'b0, 16'h0, 1'b1, 1'b1); step();
        set_in(2'd2, 1'b1, 16'h1111, 1'b1, 1'b1); step();
        set_in(2'd2, 1'b1, 16'h2222, 1'b1, 1'b1);
        #1 check("t2_first", {16'b0, out_data}, 32'h1111);
        step();
        set_in(2'd2, 1'b1, 16'h3333, 1'b0, 1'b1);
        #1 check("t2_second", {16'b0, out_data}, 32'h2222);
        check("t2_stall_ir", {31'b0, in_ready}, 0);
        step();
        #1 check("t2_held", {16'b0, out_data}, 32'h2222);
        step();

        // FIFO fill/drain with wrap
        set_in(2'd3, 1'b0, 16'h0, 1'b0, 1'b1); step();
        for (int k = 1; k <= 4; k++) begin
            set_in(2'd3, 1'b1, 16'(k), 1'b0, 1'b1); step();
        end
        set_in(2'd3, 1'b1, 16'd5, 1'b0, 1'b1);
        #1 check("t3_full_cnt", {29'b0, count}, 4);
        check("t3_full_ir", {31'b0, in_ready}, 0);
        step();
        for (int k = 1; k <= 4; k++) begin
            set_in(2'd3, 1'b0, 16'h0, 1'b1, 1'b1);
            #1 check("t3_pop", {16'b0, out_data}, k);
            step();
        end
        #1 check("t3_empty_ov", {31'b0, out_valid}, 0);
        for (int k = 11; k <= 14; k++) begin
            set_in(2'd3, 1'b1, 16'(k), 1'b0, 1'b1); step();
        end
        for (int k = 11; k <= 14; k++) begin
            set_in(2'd3, 1'b0, 16'h0, 1'b1, 1'b1);
            #1 check("t3_wrap_pop", {16'b0, out_data}, k);
            step();
        end

        // Simultaneous push/pop at count 2, then clk_en stall
        set_in(2'd3, 1'b1, 16'd21, 1'b0, 1'b1); step();
        set_in(2'd3, 1'b1, 16'd22, 1'b0, 1'b1); step();
        for (int k = 0; k < 3; k++) begin
            set_in(2'd3, 1'b1, 16'(23 + k), 1'b1, 1'b1);
            #1 check("t4_cnt", {29'b0, count}, 2);
            check("t4_head", {16'b0, out_data}, 21 + k);
            step();
        end
        set_in(2'd3, 1'b1, 16'd26, 1'b1, 1'b0);
        #1 check("t4_stall_ov", {31'b0, out_valid}, 0);
        check("t4_stall_ir", {31'b0, in_ready}, 0);
        step();
        set_in(2'd3, 1'b0, 16'h0, 1'b1, 1'b1);
        #1 check("t4_after_stall", {16'b0, out_data}, 24);
        step();

        // Config write mid-FIFO, then mode-change flush
        set_in(2'd3, 1'b1, 16'd31, 1'b0, 1'b1); step();
        set_in(2'd3, 1'b1, 16'd32, 1'b0, 1'b1); step();
        set_in(2'd3, 1'b1, 16'd33, 1'b0, 1'b1);
        config_we = 1'b1; config_data = 16'hBEEF;
        #1 check("t5_cnt3", {29'b0, count}, 3);
        check("t5_cfg_ir", {31'b0, in_ready}, 0);
        step();
        set_in(2'd3, 1'b0, 16'h0, 1'b0, 1'b1);
        #1 check("t5_cnt0", {29'b0, count}, 0);
        check("t5_reg", {16'b0, reg_value}, 32'hBEEF);
        step();
        set_in(2'd3, 1'b1, 16'd41, 1'b0, 1'b1); step();
        set_in(2'd3, 1'b1, 16'd42, 1'b0, 1'b1); step();
        set_in(2'd2, 1'b0, 16'h0, 1'b0, 1'b1); step();
        set_in(2'd3, 1'b0, 16'h0, 1'b0, 1'b1); step();
        #1 check("t5_flushed", {29'b0, count}, 0);
        check("t5_flushed_ov", {31'b0, out_valid}, 0);

`ifdef REGISTER_MODE_FIFO_FALLTHROUGH_EN
        set_in(2'd3, 1'b1, 16'h0042, 1'b1, 1'b1);
        #1 check("t6_ov", {31'b0, out_valid}, 1);
        check("t6_od", {16'b0, out_data}, 32'h0042);
        check("t6_ir", {31'b0, in_ready}, 1);
        step();
        set_in(2'd3, 1'b0, 16'h0, 1'b0, 1'b1);
        #1 check("t6_cnt", {29'b0, count}, 0);
        step();
`endif

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            in_valid    = 1'($urandom);
            in_data     = 16'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            clk_en      = ($urandom_range(0, 4) != 0);
            config_we   = ($urandom_range(0, 39) == 0);
            config_data = 16'($urandom);
            RESET       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) const_ = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
